// File: rtl/seq_mul_sched.sv
// seq_mul_sched: round-robin scheduler and control sequencer sharing one
// repeated-addition multiplier datapath among NREQ requesters.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no operation; arbitrate pending requests
// LOAD   | grant winner; load A/B from its operands, clear product
// CHECK  | test datapath B==0; capture product when finished
// ACC    | product += A and B -= 1 in the same cycle
// DONE   | one-cycle done pulse to winner; advance priority pointer
module seq_mul_sched #(
  parameter int W    = 4,
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_in,
  input  logic [NREQ*W-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [2*W-1:0]      result,
  output logic                busy,
  output logic [W-1:0]        dp_a,
  output logic [W-1:0]        dp_b,
  output logic                loadA,
  output logic                loadB,
  output logic                decB,
  output logic                loadP,
  output logic                clear,
  input  logic                zero,
  input  logic [2*W-1:0]      dp_product
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2*W-1:0]  result_q, result_d;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] idx_oh;

  // Rotating-priority search: first set request at or after the pointer.
  always_comb begin
    int j;
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state logic: sequencing, index latch, result capture, pointer advance.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (zero) begin
          result_d = dp_product;
          state_d  = S_DONE;
        end else begin
          state_d  = S_ACC;
        end
      end
      S_ACC:   state_d = S_CHECK;
      S_DONE: begin
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // One-hot form of the latched requester index.
  always_comb begin
    idx_oh        = '0;
    idx_oh[idx_q] = 1'b1;
  end

  // Moore decode; datapath strobes are held off while reset is asserted so the
  // shared datapath is not disturbed, and the product is cleared instead.
  assign busy   = (state_q != S_IDLE);
  assign gnt    = busy ? idx_oh : '0;
  assign done   = (state_q == S_DONE) ? idx_oh : '0;
  assign result = result_q;
  assign loadA  = !rst && (state_q == S_LOAD);
  assign loadB  = !rst && (state_q == S_LOAD);
  assign decB   = !rst && (state_q == S_ACC);
  assign loadP  = !rst && (state_q == S_ACC);
  assign clear  = rst  || (state_q == S_LOAD);

  // Operands follow the latched index every cycle; only LOAD consumes them.
  assign dp_a = a_in[idx_q*W +: W];
  assign dp_b = b_in[idx_q*W +: W];

endmodule

// File: tb/tb_seq_mul_sched.sv
// Scoreboard bench for seq_mul_sched with a behavioural datapath model.
module tb_seq_mul_sched;
  localparam int W    = 4;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   a_in, b_in;
  logic [NREQ-1:0]     gnt, done;
  logic [2*W-1:0]      result;
  logic                busy;
  logic [W-1:0]        dp_a, dp_b;
  logic                loadA, loadB, decB, loadP, clear;
  logic                zero;
  logic [2*W-1:0]      dp_product;

  seq_mul_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .loadA(loadA), .loadB(loadB),
    .decB(decB), .loadP(loadP), .clear(clear), .zero(zero),
    .dp_product(dp_product)
  );

  always #5 clk = ~clk;

  // Datapath model: A/B/product registers driven by the sequencer strobes.
  logic [W-1:0]   a_r = '0;
  logic [W-1:0]   b_r = '0;
  logic [2*W-1:0] p_r = '0;
  always @(posedge clk) begin
    if (loadA) a_r <= dp_a;
    if (loadB) b_r <= dp_b;
    else if (decB) b_r <= b_r - 1'b1;
    if (clear) p_r <= '0;
    else if (loadP) p_r <= p_r + {{W{1'b0}}, a_r};
  end
  assign zero       = (b_r == '0);
  assign dp_product = p_r;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NREQ-1:0] exp_done_q[$];
  logic [2*W-1:0]  exp_res_q[$];
  int ord[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: every done pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [NREQ-1:0] ed;
        logic [2*W-1:0]  er;
        ed = exp_done_q.pop_front();
        er = exp_res_q.pop_front();
        check("done_vector", 32'(done), 32'(ed));
        check("result", 32'(result), 32'(er));
        check("done_eq_gnt", 32'(gnt), 32'(done));
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic single_op(input string tag, input int i, input int a, input int b,
                           input bit perturb);
    int  lat;
    bit  seen;
    wait_idle();
    @(negedge clk);
    set_op(i, a, b);
    req[i] = 1'b1;
    exp_done_q.push_back(oh(i));
    exp_res_q.push_back((2*W)'(a * b));
    @(posedge clk); #1;
    check({tag, "_gnt"}, 32'(gnt), 32'(oh(i)));
    if (!perturb) req[i] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (perturb && lat == 4) begin
        req[i] = 1'b0;
        set_op(i, 1, 1);
      end
      if (done != '0) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(2 + 2*b));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_gnt_after"}, 32'(gnt), 32'd0);
  endtask

  // Hold req=mask and expect grants in ord[0..n-1], one idle cycle apart.
  task automatic multi_op(input string tag, input logic [NREQ-1:0] mask, input int n);
    int w;
    int gap;
    for (int k = 0; k < n; k++) begin
      exp_done_q.push_back(oh(ord[k]));
      exp_res_q.push_back((2*W)'(a_in[ord[k]*W +: W] * b_in[ord[k]*W +: W]));
    end
    @(negedge clk);
    req = mask;
    for (int k = 0; k < n; k++) begin
      w = 0;
      @(negedge clk);
      while (gnt == '0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check({tag, "_grant_order"}, 32'(gnt), 32'(oh(ord[k])));
      if (k == n - 1) begin
        req = '0;
      end else begin
        w = 0;
        while (gnt != '0 && w < 200) begin
          @(negedge clk);
          w++;
        end
        gap = 1;
        @(negedge clk);
        while (gnt == '0 && gap < 50) begin
          gap++;
          @(negedge clk);
        end
        check({tag, "_idle_gap"}, 32'(gap), 32'd1);
      end
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clear", 32'(clear), 32'd1);
    check("rst_strobes", 32'({loadA, loadB, decB, loadP}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_clear", 32'(clear), 32'd0);

    single_op("a3b2", 0, 3, 2, 1'b0);
    single_op("a5b0", 2, 5, 0, 1'b0);
    single_op("a0b3", 2, 0, 3, 1'b0);

    // Reset returns the pointer to 0 for the round-robin sweep.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_op(0, 2, 1);
    set_op(1, 3, 2);
    set_op(2, 4, 3);
    set_op(3, 5, 4);
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    multi_op("rr", 4'b1111, 5);

    single_op("req1_alone", 1, 2, 2, 1'b0);
    single_op("req3_alone", 3, 6, 2, 1'b0);
    set_op(0, 7, 1);
    set_op(1, 9, 2);
    ord[0] = 0; ord[1] = 1;
    multi_op("wrap", 4'b0011, 2);

    single_op("max", 1, 15, 15, 1'b1);

    // Abort an operation in flight with reset.
    wait_idle();
    @(negedge clk);
    set_op(2, 7, 3);
    req[2] = 1'b1;
    @(posedge clk); #1;
    check("abort_gnt", 32'(gnt), 32'(oh(2)));
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_gnt_rst", 32'(gnt), 32'd0);
    check("abort_busy_rst", 32'(busy), 32'd0);
    check("abort_clear_rst", 32'(clear), 32'd1);
    check("abort_result_rst", 32'(result), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    single_op("rerun", 2, 7, 3, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul_sched.md
Name: seq_mul_sched

Overview:
Round-robin scheduler and control-path sequencer that shares one repeated-addition multiplier datapath among NREQ requesters. It arbitrates requests and steers the winner's operands into the datapath. It then sequences the load/accumulate/decrement loop until the datapath reports B==0, and returns the product with a per-requester done pulse. It sits between the requesting blocks and the existing multiplier datapath, replacing the single-user control path.

Parameters:
W, 4, operand width in bits (A and B)
NREQ, 4, number of requesters (≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req  in  NREQ  request per requester; must hold until its gnt bit rises
a_in  in  NREQ*W  operand A per requester; slice i = bits [i*W +: W]
b_in  in  NREQ*W  operand B per requester; same slicing
gnt  out  NREQ  one-hot grant; held from LOAD through DONE inclusive
done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
result  out  2W  product; valid while done is high, held until the next done
busy  out  1  high whenever state != IDLE
dp_a  out  W  operand A to datapath (selected requester's a_in slice)
dp_b  out  W  operand B to datapath (selected requester's b_in slice)
loadA  out  1  datapath: load A register from dp_a
loadB  out  1  datapath: load B register from dp_b
decB  out  1  datapath: decrement B register
loadP  out  1  datapath: product <= product + A
clear  out  1  datapath: zero the product register
zero  in  1  datapath: B register == 0 (combinational from B register)
dp_product  in  2W  datapath product register

Behaviour:
- States: IDLE, LOAD, CHECK, ACC, DONE. Control outputs are a Moore decode of the state.
- Reset (sync):
  - state=IDLE, priority pointer=0, selected index=0.
  - gnt=0, done=0, result=0, busy=0.
  - loadA, loadB, decB and loadP are 0; clear=1 while rst is high.
- IDLE, when any req is set:
  - Select the first requester set at or after the pointer, wrapping modulo NREQ; latch its index.
  - Next state LOAD. With no request, remain in IDLE.
- LOAD (1 cycle): gnt[idx]=1; loadA=loadB=clear=1; dp_a/dp_b = slices idx. Next state CHECK.
- CHECK (1 cycle): if zero=1, capture dp_product into the result register and go to DONE; otherwise go to ACC.
- ACC (1 cycle): loadP=1 and decB=1 in the same cycle. Next state CHECK.
- DONE (1 cycle):
  - done[idx]=1; result holds the product.
  - pointer <= (idx+1) mod NREQ.
  - Next state IDLE. gnt drops at the exit of DONE.
- dp_a/dp_b are driven from slice idx in every state. Only the LOAD cycle's values are architecturally used.
- Latency, with request sampled in IDLE at cycle t and operand B=b:
  - gnt rises at t+1.
  - done pulse at t+3+2b.
  - Back-to-back: the next arbitration occurs in the IDLE cycle t+4+2b, so one idle cycle separates grants.
- Operand sampling: A and B are taken only in the LOAD cycle. Later changes to a_in/b_in or req do not affect the operation in flight.
- req dropped after grant: the operation completes and done still pulses.
- A=0: the loop still runs b iterations; result=0.
- B=0: no ACC; result=0.
- Max result (2^W-1)^2 fits in 2W bits; no overflow is possible.
- Fairness: a continuously asserted requester waits at most NREQ-1 operations.
- rst asserted mid-operation: abort on the next edge. Outputs go to reset values; no done pulse; pending requests are re-arbitrated from pointer 0 after rst falls.
- rst and req high in the same cycle: rst wins.

Test Plan:
- req[0] with A=3, B=2 at cycle t → gnt=0001 at t+1; done=0001 at t+7; result=6; busy high t+1..t+7.
- req[2] with A=5, B=0 → done=0100 at t+3, result=0. Then A=0, B=3 → done at t+9, result=0.
- req=1111 held continuously, each with distinct operands → grant order 0,1,2,3,0. Each result is correct; exactly one idle cycle between grants; done always matches gnt.
- req[1] alone after a grant to requester 3, then req=0011 → pointer=0 after 3; next grant is requester 0, then requester 1.
- A=15, B=15 → result=225 at t+33. Change a_in/b_in and drop req at t+5 → result still 225.
- rst pulsed at t+4 during A=7, B=3 → gnt=0, busy=0, clear=1 during rst, no done; rerun gives result=21.
